// File: rtl/mips789_pkg.sv
// Shared mips789 definitions: command codes, PC select codes, controller states
// and the Moore output decode for the pipeline control FSM.
package mips789_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] CMD_NOI = 3'd0;
  localparam logic [2:0] CMD_CUR = 3'd1;
  localparam logic [2:0] CMD_MUL = 3'd2;
  localparam logic [2:0] CMD_LD  = 3'd3;
  localparam logic [2:0] CMD_RET = 3'd4;

  localparam logic [3:0] PC_IGN = 4'd0;
  localparam logic [3:0] PC_KEP = 4'd1;
  localparam logic [3:0] PC_IRQ = 4'd2;
  localparam logic [3:0] PC_RST = 4'd3;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_IDLE = 3'd1,
    ST_NOI  = 3'd2,
    ST_CUR  = 3'd3,
    ST_MUL  = 3'd4,
    ST_LD   = 3'd5,
    ST_IRQ  = 3'd6,
    ST_RET  = 3'd7
  } state_e;

  typedef struct packed {
    logic       ins_clr;
    logic       ins_cls;
    logic       ctl_clr;
    logic       ctl_cls;
    logic       ra_clr;
    logic [3:0] pc;
    logic       nop;
  } ctl_t;

  // Pipeline register controls implied by each state; unknown encodings act as RST.
  function automatic ctl_t ctl_decode(input state_e st);
    ctl_t c;
    case (st)
      ST_IDLE, ST_NOI, ST_RET: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PC_IGN, 1'b0};
      ST_MUL, ST_LD:           c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PC_KEP, 1'b0};
      ST_CUR:                  c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PC_KEP, 1'b1};
      ST_IRQ:                  c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PC_IRQ, 1'b0};
      default:                 c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PC_RST, 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for interrupt request lines; bit 0 wins.
module irq_prio_enc #(
  parameter int  N_IRQ = 4,
  localparam int IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] irq,
  output logic             any,
  output logic [IW-1:0]    idx
);

  // Scan from the top so the lowest asserted index is the one left standing.
  always_comb begin
    any = |irq;
    idx = {IW{1'b0}};
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = irq[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/pipe_ctl_fsm.sv
// Pipeline control FSM: sequences multi-cycle MUL/LD stalls, CUR bubbles and
// interrupt entry/return, driving pipeline clear/hold and PC select controls.
module pipe_ctl_fsm
  import mips789_pkg::*;
#(
  parameter int  MUL_CYCLES = 33,
  parameter int  LD_CYCLES  = 1,
  parameter int  N_IRQ      = 4,
  localparam int IW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [2:0]       id_cmd,
  input  logic [N_IRQ-1:0] irq,
  output logic             iack,
  output logic [IW-1:0]    irq_id,
  output logic             id2ra_ins_clr,
  output logic             id2ra_ins_cls,
  output logic             id2ra_ctl_clr,
  output logic             id2ra_ctl_cls,
  output logic             ra2exec_ctl_clr,
  output logic [3:0]       pc_prectl,
  output logic             zz_is_nop,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_svc_q, in_svc_d;
  logic [IW-1:0]    irq_id_q, irq_id_d;
  ctl_t             ctl_q, ctl_d;
  logic             iack_q, iack_d;
  logic             busy_q, busy_d;

  logic             irq_any_s;
  logic [IW-1:0]    irq_idx_s;
  logic             pending_s;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .irq (irq),
    .any (irq_any_s),
    .idx (irq_idx_s)
  );

  // iack_q already reflects the current state, so it masks new requests directly.
  assign pending_s = irq_any_s & ~iack_q;

  // Next-state, delay counter, in-service flag and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_svc_d = in_svc_q;
    irq_id_d = irq_id_q;
    if (!pause) begin
      case (state_q)
        ST_RST: state_d = ST_IDLE;
        ST_IDLE, ST_NOI: begin
          if (pending_s) begin
            state_d  = ST_IRQ;
            irq_id_d = irq_idx_s;
          end else begin
            case (id_cmd)
              CMD_NOI: state_d = ST_NOI;
              CMD_CUR: state_d = ST_CUR;
              CMD_MUL: begin
                state_d = ST_MUL;
                cnt_d   = {CNT_W{1'b0}};
              end
              CMD_LD: begin
                state_d = ST_LD;
                cnt_d   = {CNT_W{1'b0}};
              end
              CMD_RET: state_d = ST_RET;
              default: state_d = ST_IDLE;
            endcase
          end
        end
        ST_CUR: state_d = ST_NOI;
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_LD: begin
          if (cnt_q == LD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_IRQ:  state_d = ST_IDLE;
        ST_RET:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // The flag carries iack from IRQ through the handler until RET.
      if (state_d == ST_RET) begin
        in_svc_d = 1'b0;
      end else if (state_q == ST_IRQ) begin
        in_svc_d = 1'b1;
      end else begin
        in_svc_d = in_svc_q;
      end
    end else begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_svc_d = in_svc_q;
      irq_id_d = irq_id_q;
    end
    ctl_d  = ctl_decode(state_d);
    iack_d = (state_d == ST_IRQ) | (in_svc_d & (state_d != ST_RET));
    busy_d = (state_d == ST_MUL) | (state_d == ST_LD);
  end

  // State, counter and registered outputs; reset aborts any stall immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RST;
      cnt_q    <= {CNT_W{1'b0}};
      in_svc_q <= 1'b0;
      irq_id_q <= {IW{1'b0}};
      ctl_q    <= ctl_decode(ST_RST);
      iack_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_svc_q <= in_svc_d;
      irq_id_q <= irq_id_d;
      ctl_q    <= ctl_d;
      iack_q   <= iack_d;
      busy_q   <= busy_d;
    end
  end

  assign iack            = iack_q;
  assign irq_id          = irq_id_q;
  assign id2ra_ins_clr   = ctl_q.ins_clr;
  assign id2ra_ins_cls   = ctl_q.ins_cls;
  assign id2ra_ctl_clr   = ctl_q.ctl_clr;
  assign id2ra_ctl_cls   = ctl_q.ctl_cls;
  assign ra2exec_ctl_clr = ctl_q.ra_clr;
  assign pc_prectl       = ctl_q.pc;
  assign zz_is_nop       = ctl_q.nop;
  assign busy            = busy_q;

endmodule
